// File: rtl/fifo_umbral_if.sv
// Write/read handshake bundle between a producer/consumer and one fifo_umbral buffer.
// Pure wiring, no latency of its own.
// Backpressure is not signalled here; the FIFO's count and flags tell the producer when to hold off.
interface fifo_umbral_if #(
    parameter int DATA_WIDTH = 6
);
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;

    // Producer/consumer side drives requests and write data, and receives read data.
    modport master (
        output push, pop, data_in,
        input  data_out, valid_out
    );

    // FIFO side.
    modport slave (
        input  push, pop, data_in,
        output data_out, valid_out
    );
endinterface

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with live low/high occupancy thresholds and a sticky overflow/underflow flag.
// Latency: a pushed word can be popped on the next edge; popped data is registered, valid one cycle after the pop.
// Backpressure: a push to a full FIFO is dropped (unless a pop frees a slot that cycle) and a pop on empty is ignored; both set fifo_error.
module fifo_umbral #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_umbral_if.slave          bus,
    input  logic [4:0]            low_th,
    input  logic [4:0]            high_th,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  fifo_error
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    // Common width for the threshold compare so neither side is truncated.
    localparam int CW = (ADDR_WIDTH + 1 > 5) ? ADDR_WIDTH + 1 : 5;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  pop_ok;
    logic                  push_ok;
    logic [CW-1:0]         count_ext;
    logic [CW-1:0]         low_ext;
    logic [CW-1:0]         high_ext;

    // Accept decisions: a pop on a full FIFO frees the slot the same-cycle push uses.
    always_comb begin
        pop_ok  = bus.pop & (count != '0);
        push_ok = bus.push & ((count != FULL_CNT) | pop_ok);
    end

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Pointers and occupancy; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered read port: data_out holds its last word when nothing is popped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
        end else begin
            bus.valid_out <= pop_ok;
            if (pop_ok) begin
                bus.data_out <= mem[rd_ptr];
            end
        end
    end

    // Sticky error: only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_error <= 1'b0;
        end else if ((bus.push & ~push_ok) | (bus.pop & (count == '0))) begin
            fifo_error <= 1'b1;
        end
    end

    // Flags track the registered count against the live thresholds.
    always_comb begin
        count_ext    = CW'(count);
        low_ext      = CW'(low_th);
        high_ext     = CW'(high_th);
        fifo_empty   = (count == '0);
        fifo_full    = (count == FULL_CNT);
        almost_empty = (count_ext <= low_ext);
        almost_full  = (count_ext >= high_ext);
    end
endmodule

// File: tb/tb_fifo_umbral.sv
// Self-checking bench for fifo_umbral: scoreboard queue of pushed words, compared as words emerge.
// Occupancy, flags and error are checked every cycle against a small reference count.
module tb_fifo_umbral;
    localparam int DW = 6;
    localparam int AW = 4;

    logic          clk;
    logic          reset;
    logic [4:0]    low_th;
    logic [4:0]    high_th;
    logic [AW:0]   count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_empty;
    logic          almost_full;
    logic          fifo_error;

    fifo_umbral_if #(.DATA_WIDTH(DW)) bus ();

    fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .low_th       (low_th),
        .high_th      (high_th),
        .count        (count),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .fifo_error   (fifo_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [DW-1:0] sb[$];
    int          mcnt = 0;
    logic        merr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_flags();
        chk("fifo_empty", 32'(fifo_empty), 32'(mcnt == 0));
        chk("fifo_full", 32'(fifo_full), 32'(mcnt == 16));
        chk("almost_empty", 32'(almost_empty), 32'(mcnt <= int'(low_th)));
        chk("almost_full", 32'(almost_full), 32'(mcnt >= int'(high_th)));
    endtask

    // One clock of stimulus; expected words enter the scoreboard as they are pushed.
    task automatic cycle(input logic p, input logic r, input logic [DW-1:0] d);
        bit pop_ok;
        bit push_ok;
        pop_ok  = r && (mcnt != 0);
        push_ok = p && ((mcnt != 16) || pop_ok);
        if ((p && !push_ok) || (r && mcnt == 0)) merr = 1'b1;
        if (push_ok) sb.push_back(d);
        mcnt = mcnt + int'(push_ok) - int'(pop_ok);
        bus.push    = p;
        bus.pop     = r;
        bus.data_in = d;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        chk("valid_out", 32'(bus.valid_out), 32'(pop_ok));
        if (bus.valid_out) begin
            if (sb.size() == 0) chk("sb_nonempty", 32'(0), 32'(1));
            else chk("data_out", 32'(bus.data_out), 32'(sb.pop_front()));
        end
        chk("count", 32'(count), 32'(mcnt));
        chk("fifo_error", 32'(fifo_error), 32'(merr));
        check_flags();
    endtask

    // Reset pulse between edges; state must clear without waiting for a clock.
    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        sb.delete();
        mcnt = 0;
        merr = 1'b0;
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_error", 32'(fifo_error), 32'(0));
        chk("rst_valid", 32'(bus.valid_out), 32'(0));
        check_flags();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic p;
        logic r;
        reset       = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
        low_th      = 5'd2;
        high_th     = 5'd14;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(count), 32'(0));
        chk("reset_empty", 32'(fifo_empty), 32'(1));
        chk("reset_ae", 32'(almost_empty), 32'(1));
        chk("reset_af", 32'(almost_full), 32'(0));
        chk("reset_error", 32'(fifo_error), 32'(0));
        chk("reset_valid", 32'(bus.valid_out), 32'(0));
        chk("reset_data", 32'(bus.data_out), 32'(0));
        reset = 1'b1;

        // Ordering: fill 0x01..0x10, then drain
        for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, DW'(i));
        chk("full_after_16", 32'(fifo_full), 32'(1));
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, '0);
        chk("empty_after_drain", 32'(fifo_empty), 32'(1));

        // Full with simultaneous push/pop, then overflow
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, DW'(i + 16));
        cycle(1'b1, 1'b1, 6'h2A);
        chk("full_pp_count", 32'(count), 32'(16));
        chk("full_pp_error", 32'(fifo_error), 32'(0));
        cycle(1'b1, 1'b0, 6'h3F);
        chk("overflow_error", 32'(fifo_error), 32'(1));
        chk("overflow_count", 32'(count), 32'(16));
        // Drain: 0x3F must not appear, 0x2A is last; error stays set throughout
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, '0);
        pulse_reset();

        // Underflow
        cycle(1'b0, 1'b1, '0);
        chk("underflow_valid", 32'(bus.valid_out), 32'(0));
        chk("underflow_error", 32'(fifo_error), 32'(1));
        pulse_reset();
        chk("error_cleared", 32'(fifo_error), 32'(0));

        // Random traffic across pointer wrap
        for (int i = 0; i < 40; i++) begin
            p = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (mcnt == 0) r = 1'b0;
            if (mcnt == 16 && !r) p = 1'b0;
            cycle(p, r, DW'($urandom_range(0, 63)));
        end
        pulse_reset();

        // Live thresholds and asynchronous reset
        low_th  = 5'd4;
        high_th = 5'd6;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(i + 40));
        chk("th_ae_before", 32'(almost_empty), 32'(0));
        chk("th_af_before", 32'(almost_full), 32'(0));
        low_th  = 5'd5;
        high_th = 5'd5;
        #1;
        chk("th_ae_after", 32'(almost_empty), 32'(1));
        chk("th_af_after", 32'(almost_full), 32'(1));
        low_th  = 5'd20;
        high_th = 5'd0;
        #1;
        chk("th_low_big", 32'(almost_empty), 32'(1));
        chk("th_high_zero", 32'(almost_full), 32'(1));
        low_th  = 5'd4;
        high_th = 5'd6;
        #1;
        chk("th_restored_af", 32'(almost_full), 32'(0));
        reset = 1'b0;
        #1;
        chk("async_count", 32'(count), 32'(0));
        chk("async_empty", 32'(fifo_empty), 32'(1));
        sb.delete();
        mcnt  = 0;
        merr  = 1'b0;
        reset = 1'b1;
        cycle(1'b1, 1'b0, 6'h15);
        cycle(1'b0, 1'b1, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/fifo_umbral.md
# fifo_umbral

Parameterized synchronous FIFO with programmable low/high occupancy thresholds and sticky overflow/underflow error detection. One instance sits on each buffer of the switch datapath: the main FIFO, VC0, VC1, D0 and D1. Each instance takes its `*_l`/`*_h` threshold pair from the control FSM's registered threshold outputs. Each instance returns its `fifo_empty` and `fifo_error` bits, which are concatenated into the FSM's `empties` and `errors` buses.

## Interface
- `DATA_WIDTH`, 6, width of each stored word.
- `ADDR_WIDTH`, 4, address width; depth is `DEPTH = 2**ADDR_WIDTH` (16).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `push`  in  1  write request.
- `data_in`  in  DATA_WIDTH  word to write.
- `pop`  in  1  read request.
- `low_th`  in  5  almost-empty threshold, in words.
- `high_th`  in  5  almost-full threshold, in words.
- `data_out`  out  DATA_WIDTH  registered read word.
- `valid_out`  out  1  `data_out` holds a word popped on the previous cycle.
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `fifo_empty`  out  1  `count == 0`.
- `fifo_full`  out  1  `count == DEPTH`.
- `almost_empty`  out  1  `count <= low_th`.
- `almost_full`  out  1  `count >= high_th`.
- `fifo_error`  out  1  sticky overflow/underflow flag.

## Operation
- **Storage and pointers**
  - Storage is a DEPTH x DATA_WIDTH register array.
  - `wr_ptr` and `rd_ptr` are ADDR_WIDTH bits wide and wrap naturally from DEPTH-1 to 0.
  - `count` is a separate ADDR_WIDTH+1 register.
- **Pop acceptance:** `pop_ok = pop & (count != 0)`.
- **Push acceptance:** `push_ok = push & ((count != DEPTH) | pop_ok)`.
  - When the FIFO is full, a simultaneous push and pop are both accepted.
  - When the FIFO is empty, a simultaneous push and pop accept only the push. No bypass: the written word is not readable in the same cycle.
- **On `push_ok`:** `mem[wr_ptr] <= data_in`; `wr_ptr++`.
- **On `pop_ok`:** `data_out <= mem[rd_ptr]`; `rd_ptr++`; `valid_out <= 1`.
- **No `pop_ok`:** `valid_out <= 0` and `data_out` holds its last value.
- **Count update:**
  - `count +1` on `push_ok & ~pop_ok`.
  - `count -1` on `pop_ok & ~push_ok`.
  - Unchanged otherwise.
- **Overflow:** `push & ~push_ok` drops the word, leaves pointers and count unchanged, and sets `fifo_error`.
- **Underflow:** `pop & (count == 0)` is ignored, keeps `valid_out` at 0, and sets `fifo_error`.
- `fifo_error` stays at 1 until `reset` is asserted. The FSM's ERROR state clears it by driving reset.
- **Flags:**
  - `fifo_empty`, `fifo_full`, `almost_empty` and `almost_full` are combinational from the registered `count` and the live `low_th`/`high_th`.
  - Threshold changes take effect in the same cycle.
  - The threshold compare is unsigned 5-bit against the zero-extended `count`.
  - `high_th = 0` forces `almost_full` to 1.
  - `low_th >= DEPTH` forces `almost_empty` to 1.
- **Reset values (while `reset = 0`):**
  - Pointers, `count`, `data_out`, `valid_out` and `fifo_error` are 0.
  - `fifo_empty` = 1, `fifo_full` = 0.
  - `almost_empty` = 1.
  - `almost_full` = 1 only if `high_th = 0`.
  - Memory contents are not reset.
- **Reset mid-operation:** asserting reset discards all stored words immediately, without waiting for a clock edge. Deassertion takes effect at the next rising edge.

## Timing
- **Write to count:** push at edge N makes `count` and the flags reflect the new word after edge N.
- **Read latency:** a word pushed at edge N can be popped at edge N+1 at the earliest. It appears on `data_out` with `valid_out = 1` after edge N+1.
- **Pop timing:** a pop at edge N gives `data_out`/`valid_out` valid during the cycle after edge N, for exactly one cycle per accepted pop.
- **Back-to-back pops:** sustain one word per cycle; `valid_out` stays high.
- **Error timing:** `fifo_error` rises after the edge at which the illegal request is sampled.

## Test plan
- **Reset:** hold `reset = 0` with `low_th = 2`, `high_th = 14`, then release.
  - Required: `count = 0`, `fifo_empty = 1`, `almost_empty = 1`, `almost_full = 0`, `fifo_error = 0`, `valid_out = 0`.
- **Ordering:** push 0x01..0x10 on 16 consecutive cycles, then pop 16 times.
  - Required: `fifo_full = 1` after the 16th push; `almost_full` rises when `count = 14`.
  - Required: `data_out` returns 0x01..0x10 in order with `valid_out = 1` each cycle; `fifo_empty = 1` at the end; `fifo_error = 0`.
- **Full with simultaneous push/pop:** fill to 16, then push 0x2A with pop in the same cycle.
  - Required: the oldest word is read, `count` stays 16, and `fifo_error` stays 0.
  - Then push 0x3F alone. Required: the word is dropped, `count = 16`, `fifo_error = 1`, and the error persists until reset.
- **Underflow:** pop on an empty FIFO.
  - Required: `valid_out = 0`, `count = 0`, `fifo_error = 1`.
  - Then pulse `reset` low. Required: `fifo_error = 0`.
- **Wrap-around:** run 40 cycles of random push/pop with at most 16 outstanding words.
  - Required: the scoreboard matches every popped word.
  - Required: `count` equals pushes minus pops at all times across pointer wrap.
- **Live thresholds and asynchronous reset:** with `count = 5`, change `low_th` 4→5 and `high_th` 6→5.
  - Required: `almost_empty` goes 0→1 and `almost_full` goes 0→1 in the same cycle.
  - Then assert `reset` between clock edges. Required: `count = 0` and `fifo_empty = 1` before the next edge.
